// File: rtl/axi_pkg.sv
// Shared AXI constants, read-master state encoding and a constant-evaluable log2
// used by the burst masters.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_AR   = 3'd2,
    ST_R    = 3'd3,
    ST_DONE = 3'd4
  } rd_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/axi_burst_calc.sv
// Burst sizing: min(remaining, MAX_BURST, beats left before the next BOUNDARY)
// and the byte address following that burst.
module axi_burst_calc
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16,
  parameter int BOUNDARY   = 4096
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  remaining,
  output logic [8:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int ADDR_LSB = clog2(BYTES);
  localparam int BND_BITS = clog2(BOUNDARY);

  logic [BND_BITS:0] bnd_off;
  logic [BND_BITS:0] to_bnd_bytes;
  logic [31:0]       to_bnd;
  logic [31:0]       cand;

  // NOTE: every always_comb output gets a value on every path first, so no latch is inferred.
  always_comb begin
    bnd_off      = {1'b0, addr[BND_BITS-1:0]};
    to_bnd_bytes = (BND_BITS+1)'(BOUNDARY) - bnd_off;
    to_bnd       = 32'(to_bnd_bytes >> ADDR_LSB);
    cand         = 32'(remaining);
    if (cand > 32'(MAX_BURST)) cand = 32'(MAX_BURST);
    if (cand > to_bnd)         cand = to_bnd;
    burst        = 9'(cand);
    next_addr    = addr + (ADDR_WIDTH'(burst) << ADDR_LSB);
  end

endmodule

// File: rtl/axi_rd_burst_master.sv
// AXI4 read master: splits one user request into boundary-safe INCR bursts,
// one outstanding at a time, with optional beat-address pattern checking.
module axi_rd_burst_master
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16,
  parameter int BOUNDARY   = 4096,
  parameter int CHECK_EN   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_end,
  input  logic                  rd_trig,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [LEN_WIDTH-1:0]  rd_len,
  output logic                  rd_ready,
  output logic                  rd_done,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  input  logic                  rd_data_ready,
  output logic                  rd_error,
  output logic                  rd_bus_err,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int ADDR_LSB = clog2(BYTES);
  localparam int WORD_W   = ADDR_WIDTH - ADDR_LSB;

  rd_state_e             state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, araddr_q, calc_next;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [8:0]            burst_q, beat_cnt, calc_burst;
  logic [7:0]            arlen_q;
  logic [WORD_W-1:0]     chk_addr;
  logic                  rd_error_q, bus_err_q;
  logic                  accept, r_hs, last_beat, mismatch, beat_bad;

  axi_burst_calc #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH),
    .MAX_BURST(MAX_BURST),   .BOUNDARY(BOUNDARY)
  ) u_calc (
    .addr(addr_q), .remaining(rem_q), .burst(calc_burst), .next_addr(calc_next)
  );

  assign accept    = (state == ST_IDLE) && rd_trig && init_end;
  assign r_hs      = (state == ST_R) && axi_rvalid && rd_data_ready;
  assign last_beat = (beat_cnt == 9'd1);
  assign mismatch  = (CHECK_EN != 0) && (axi_rdata != DATA_WIDTH'(chk_addr));
  // Burst length is owned by our beat counter; rlast is only cross-checked.
  assign beat_bad  = (axi_rresp != AXI_RESP_OKAY) || (axi_rlast != last_beat);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = (rd_len == '0) ? ST_DONE : ST_CALC;
      ST_CALC: state_nxt = ST_AR;
      ST_AR:   if (axi_arready) state_nxt = ST_R;
      ST_R:    if (r_hs && last_beat) state_nxt = (rem_q != '0) ? ST_CALC : ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      araddr_q   <= '0;
      rem_q      <= '0;
      burst_q    <= '0;
      beat_cnt   <= '0;
      arlen_q    <= '0;
      chk_addr   <= '0;
      rd_error_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        ST_IDLE: if (accept) begin
          addr_q     <= rd_addr;
          rem_q      <= rd_len;
          chk_addr   <= WORD_W'(rd_addr >> ADDR_LSB);
          rd_error_q <= 1'b0;
          bus_err_q  <= 1'b0;
        end
        ST_CALC: begin
          araddr_q <= addr_q;
          arlen_q  <= 8'(calc_burst - 9'd1);
          burst_q  <= calc_burst;
        end
        ST_AR: if (axi_arready) begin
          addr_q   <= calc_next;
          rem_q    <= rem_q - LEN_WIDTH'(burst_q);
          beat_cnt <= burst_q;
        end
        ST_R: if (r_hs) begin
          beat_cnt <= beat_cnt - 9'd1;
          chk_addr <= chk_addr + 1'b1;
          if (mismatch) rd_error_q <= 1'b1;
          if (beat_bad) bus_err_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_ready      = (state == ST_IDLE);
  assign rd_done       = (state == ST_DONE);
  assign axi_arvalid   = (state == ST_AR);
  assign axi_araddr    = araddr_q;
  assign axi_arlen     = arlen_q;
  assign axi_arsize    = 3'(clog2(BYTES));
  assign axi_arburst   = AXI_BURST_INCR;
  assign axi_rready    = (state == ST_R) && rd_data_ready;
  assign rd_data_valid = (state == ST_R) && axi_rvalid;
  assign rd_data       = (state == ST_R) ? axi_rdata : '0;
  assign rd_error      = rd_error_q;
  assign rd_bus_err    = bus_err_q;

endmodule
